seven_seg_scan: RTL

Time-multiplexed driver for a bank of common-anode 7-segment digits with active-low anodes, segments and decimal point.
- Scans `N_DIGITS` hex digits from a packed value with a programmable refresh divider.
- Captures new values through a load strobe into a shadow register and commits them only at frame boundaries, so no frame is ever torn.
- Sits between user logic (switches, counters) and the board display pins; it is the generalised successor of the fixed single-digit display top.

---
 rtl/sevseg_pkg.sv | 16 +
 rtl/sevseg_refresh.sv | 34 +++
 rtl/seven_seg_scan.sv | 110 +++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Shared 7-segment constants and hex decoder for the display blocks.
// Encodings are active-low, bit order g..a (seg[6]=g, seg[0]=a).
package sevseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_LUT[hex];
    endfunction

endpackage

// File: rtl/sevseg_refresh.sv
// Refresh divider and digit scan index; wrap marks the last tick of a frame.
module sevseg_refresh #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode hex display driver with tear-free shadow loading.
// Optional leading-zero blanking is enabled by defining SEVSEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan
    import sevseg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  dp,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                              tick;
    logic                              wrap;
    logic [IDX_W-1:0]                  idx;
    logic [N_DIGITS-1:0][3:0]          shadow_data, disp_data;
    logic [N_DIGITS-1:0]               shadow_dp, disp_dp;
    logic                              commit;
    logic [N_DIGITS-1:0]               an_next;
    logic [6:0]                        seg_next;

    sevseg_refresh #(
        .N_DIGITS    (N_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .IDX_W       (IDX_W)
    ) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .idx  (idx),
        .wrap (wrap)
    );

    assign commit = tick && wrap && pending_o;

    // Commit reads the old shadow; a same-edge load then re-arms pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            pending_o   <= 1'b0;
        end else begin
            if (commit) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
                pending_o <= 1'b0;
            end
            if (load_i) begin
                shadow_data <= data_i;
                shadow_dp   <= dp_i;
                pending_o   <= 1'b1;
            end
        end
    end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] blank;
    logic                zero_above;

    // blank[i] set when nibble i and every higher nibble are zero; digit 0 never blanks.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_data[i] == 4'h0);
            blank[i]   = zero_above;
        end
    end

    always_comb begin
        seg_next = blank[idx] ? SEG_BLANK : hex_to_seg(disp_data[idx]);
    end
`else
    always_comb begin
        seg_next = hex_to_seg(disp_data[idx]);
    end
`endif

    always_comb begin
        an_next      = '1;
        an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an      <= '1;
            seg     <= SEG_BLANK;
            dp      <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            an      <= an_next;
            seg     <= seg_next;
            dp      <= ~disp_dp[idx];
            frame_o <= wrap;
        end
    end

endmodule
